signed_div_seq: RTL and testbench
=================================

SIGNED_DIV_SEQ -- requirements
Module: signed_div_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/quotient/remainder width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request to begin a division; sampled only in IDLE.
REQ-005 SHALL have port dividend  input  WIDTH  signed two's-complement dividend; captured on the start edge.
REQ-006 SHALL have port divisor  input  WIDTH  signed two's-complement divisor; captured on the start edge.
REQ-007 SHALL have port busy  output  1  high in every state except IDLE.
REQ-008 SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-009 SHALL have port result  output  2*WIDTH  {remainder (HI), quotient (LO)}; held until next done.
REQ-010 SHALL have port div_by_zero  output  1  set with done when captured divisor was 0; held with result.

Function
REQ-011 SHALL implement FSM IDLE -> ABS -> DIV -> FIX -> IDLE, one state per cycle except DIV.
REQ-012 IDLE: start=1 SHALL capture operands, record sign_q = sign(dividend) XOR sign(divisor), sign_r = sign(dividend), and go to ABS.
REQ-013 ABS SHALL replace each captured operand by its magnitude (conditional two's complement) as WIDTH-bit unsigned; -2^(WIDTH-1) maps to unsigned 2^(WIDTH-1).
REQ-014 DIV SHALL run exactly WIDTH cycles of unsigned restoring division, one quotient bit per cycle, MSB first, with a WIDTH+1-bit partial remainder.
REQ-015 FIX SHALL negate quotient if sign_q and remainder if sign_r (truncating division; remainder takes dividend sign).
REQ-016 done SHALL rise exactly WIDTH+2 cycles after the start-sampling edge (34 for WIDTH=32) and stay high one cycle.
REQ-017 result and div_by_zero SHALL update only on the edge that raises done.
REQ-018 start while busy SHALL be ignored; no queueing.
REQ-019 start in the same cycle done is high SHALL be accepted (FSM is in IDLE that cycle).
REQ-020 Divisor 0 SHALL still take the full latency, then give quotient all-ones, remainder = original signed dividend, div_by_zero=1.
REQ-021 -2^(WIDTH-1) / -1 SHALL give quotient 0x80000000 (wrapped) and remainder 0, div_by_zero=0.
REQ-022 Zero dividend SHALL give quotient 0 and remainder 0 regardless of signs.

Reset
REQ-023 rst_n low SHALL force FSM to IDLE, busy=0, done=0, div_by_zero=0, result=0, iteration counter=0, asynchronously.
REQ-024 Reset during ABS/DIV/FIX SHALL abandon the operation with no done pulse.
REQ-025 After rst_n deasserts, the first start SHALL be accepted on the first rising edge.

Structure
REQ-026 Package div_pkg SHALL hold the FSM state enum, DIV_WIDTH=32 and the iteration-counter width constant.
REQ-027 SHALL instantiate sub-module cond_negate (enable, WIDTH-bit in/out; out = enable ? -in : in), used by ABS and FIX.
REQ-028 Iteration counter SHALL be $clog2(WIDTH)+1 bits; no other multi-cycle datapath registers beyond operands, partial remainder, quotient.

Verification
REQ-029 100 / 7 -> after 34 cycles done=1, result={32'd2, 32'd14}, div_by_zero=0.
REQ-030 -100 / 7 -> quotient 0xFFFFFFF2 (-14), remainder 0xFFFFFFFE (-2); 100 / -7 -> quotient -14, remainder 2.
REQ-031 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0; 0x80000000 / 1 -> quotient 0x80000000, remainder 0.
REQ-032 5 / 0 -> after 34 cycles quotient 0xFFFFFFFF, remainder 5, div_by_zero=1.
REQ-033 start at cycles 0, 10 and 34 -> only cycles 0 and 34 accepted; done at 34 and 68; second operands unaffected by cycle-10 inputs.
REQ-034 rst_n low at cycle 20 of a division -> busy=0 immediately, no done, result=0; next start completes normally.

Source files
------------

// File: rtl/div_pkg.sv
// div_pkg -- shared definitions for the sequential signed divider.
//   divState_t : controller states (IDLE -> ABS -> DIV -> FIX -> IDLE)
//   DIV_WIDTH  : default operand width
//   cntWidth() : iteration-counter width for a given operand width
//   CNT_WIDTH  : iteration-counter width for DIV_WIDTH
package div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ABS  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } divState_t;

  localparam int DIV_WIDTH = 32;

  // One extra bit so the counter can also hold the value WIDTH itself.
  function automatic int cntWidth(input int width);
    return $clog2(width) + 1;
  endfunction

  localparam int CNT_WIDTH = cntWidth(DIV_WIDTH);

endpackage

// File: rtl/cond_negate.sv
// cond_negate -- conditional two's-complement negation.
//   i_enable : 1 = negate, 0 = pass through
//   i_in     : WIDTH-bit input value
//   o_out    : i_enable ? -i_in : i_in (wraps, so the most negative value maps to itself)
module cond_negate #(
  parameter int WIDTH = 32
) (
  input  logic             i_enable,
  input  logic [WIDTH-1:0] i_in,
  output logic [WIDTH-1:0] o_out
);

  assign o_out = i_enable ? (~i_in + 1'b1) : i_in;

endmodule

// File: rtl/signed_div_seq.sv
// signed_div_seq -- multi-cycle signed (truncating) divider using restoring division.
//   clk         : clock, all state changes on the rising edge
//   rst_n       : asynchronous active-low reset
//   start       : begin a division (only looked at while idle)
//   dividend    : signed dividend, captured with start
//   divisor     : signed divisor, captured with start
//   busy        : high whenever the controller is not idle
//   done        : one-cycle pulse when result is updated
//   result      : {remainder, quotient}, held until the next done
//   div_by_zero : captured divisor was zero, updated together with result
// Latency: done rises WIDTH+2 edges after the edge that accepted start.
module signed_div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               div_by_zero
);

  localparam int CntW = cntWidth(WIDTH);

  divState_t        r_state;
  divState_t        w_nextState;

  logic [WIDTH-1:0] r_dividend;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;
  logic [CntW-1:0]  r_count;
  logic             r_signQ;
  logic             r_signR;
  logic             r_done;
  logic             r_dbz;
  logic [2*WIDTH-1:0] r_result;

  logic             w_lastIter;
  logic             w_divZero;
  logic [WIDTH:0]   w_partial;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;

  logic             w_negAEn;
  logic             w_negBEn;
  logic [WIDTH-1:0] w_negAIn;
  logic [WIDTH-1:0] w_negBIn;
  logic [WIDTH-1:0] w_negAOut;
  logic [WIDTH-1:0] w_negBOut;

  assign w_lastIter = (r_count == CntW'(WIDTH - 1));

  // The divisor register keeps its magnitude from ABS onward, so a zero
  // here means the captured divisor was zero.
  assign w_divZero  = (r_divisor == '0);

  // Partial remainder is WIDTH+1 bits once the next dividend bit is shifted
  // in. The stored remainder is always below the divisor, so it fits in
  // WIDTH bits; the borrow bit of the trial subtraction decides the quotient bit.
  assign w_partial  = {r_rem, r_dividend[WIDTH-1]};
  assign w_diff     = w_partial - {1'b0, r_divisor};
  assign w_ge       = ~w_diff[WIDTH];

  // The two negators are shared: ABS takes operand magnitudes, FIX applies
  // the result signs. A zero divisor keeps the all-ones quotient unsigned.
  always_comb begin
    w_negAIn = r_dividend;
    w_negAEn = r_dividend[WIDTH-1];
    w_negBIn = r_divisor;
    w_negBEn = r_divisor[WIDTH-1];
    if (r_state == ST_FIX) begin
      w_negAIn = r_quot;
      w_negAEn = r_signQ & ~w_divZero;
      w_negBIn = r_rem;
      w_negBEn = r_signR;
    end
  end

  cond_negate #(.WIDTH(WIDTH)) u_negA (
    .i_enable (w_negAEn),
    .i_in     (w_negAIn),
    .o_out    (w_negAOut)
  );

  cond_negate #(.WIDTH(WIDTH)) u_negB (
    .i_enable (w_negBEn),
    .i_in     (w_negBIn),
    .o_out    (w_negBOut)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic; DIV is the only state that lasts more than one cycle.
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      ST_IDLE: if (start) w_nextState = ST_ABS;
      ST_ABS:  w_nextState = ST_DIV;
      ST_DIV:  if (w_lastIter) w_nextState = ST_FIX;
      ST_FIX:  w_nextState = ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    busy = (r_state != ST_IDLE);
  end

  // Datapath: capture, magnitude, one restoring step per DIV cycle, sign fix.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dividend <= '0;
      r_divisor  <= '0;
      r_quot     <= '0;
      r_rem      <= '0;
      r_count    <= '0;
      r_signQ    <= 1'b0;
      r_signR    <= 1'b0;
      r_done     <= 1'b0;
      r_dbz      <= 1'b0;
      r_result   <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_dividend <= dividend;
            r_divisor  <= divisor;
            r_signQ    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_signR    <= dividend[WIDTH-1];
          end
        end
        ST_ABS: begin
          r_dividend <= w_negAOut;
          r_divisor  <= w_negBOut;
          r_quot     <= '0;
          r_rem      <= '0;
          r_count    <= '0;
        end
        ST_DIV: begin
          r_dividend <= {r_dividend[WIDTH-2:0], 1'b0};
          r_rem      <= w_ge ? w_diff[WIDTH-1:0] : w_partial[WIDTH-1:0];
          r_quot     <= {r_quot[WIDTH-2:0], w_ge};
          r_count    <= r_count + 1'b1;
        end
        ST_FIX: begin
          r_result <= {w_negBOut, w_negAOut};
          r_dbz    <= w_divZero;
          r_done   <= 1'b1;
        end
        default: begin
          r_done <= 1'b0;
        end
      endcase
    end
  end

  assign done        = r_done;
  assign result      = r_result;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_signed_div_seq.sv
// tb_signed_div_seq -- self-checking bench for signed_div_seq (WIDTH = 32).
// Expected results come from plain signed integer arithmetic on longint.
module tb_signed_div_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [63:0] result;
  logic        div_by_zero;

  int testsRun = 0;
  int testsFailed = 0;
  logic [63:0] lastExpResult = '0;

  signed_div_seq #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Truncating signed division; zero divisor yields all-ones quotient and
  // the dividend as remainder. Results wrap to 32 bits.
  function automatic void modelDivide(input logic [31:0] a, input logic [31:0] b,
                                      output logic [63:0] expResult,
                                      output logic expDbz);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) begin
      q = -1;
      r = sa;
      expDbz = 1'b1;
    end else begin
      q = sa / sb;
      r = sa % sb;
      expDbz = 1'b0;
    end
    expResult = {r[31:0], q[31:0]};
  endfunction

  // Starts a division right now (caller is away from the clock edge), then
  // waits a bounded number of edges for done. injectAt > 0 drives a stray
  // start with junk operands just before that edge to confirm it is ignored.
  task automatic applyStimulus(input string tag, input logic [31:0] a,
                               input logic [31:0] b, input int injectAt);
    int cycles;
    logic [63:0] expResult;
    logic expDbz;
    modelDivide(a, b, expResult, expDbz);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    checkOutput({tag, ".busy"}, {63'd0, busy}, 64'd1);
    cycles = 0;
    while (cycles < 100) begin
      if (cycles + 1 == injectAt) begin
        start    = 1'b1;
        dividend = $urandom;
        divisor  = $urandom;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      cycles++;
      if (done) break;
      if (cycles == 20) checkOutput({tag, ".held"}, result, lastExpResult);
    end
    checkOutput({tag, ".latency"}, 64'(cycles), 64'd34);
    checkOutput({tag, ".result"}, result, expResult);
    checkOutput({tag, ".dbz"}, {63'd0, div_by_zero}, {63'd0, expDbz});
    lastExpResult = expResult;
  endtask

  logic [31:0] dirA [9] = '{32'd100, -32'sd100, 32'd100, 32'h8000_0000, 32'h8000_0000,
                            32'd5, 32'd0, 32'd0, -32'sd5};
  logic [31:0] dirB [9] = '{32'd7, 32'd7, -32'sd7, 32'hFFFF_FFFF, 32'd1,
                            32'd0, -32'sd5, 32'd0, 32'd0};

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    int sel;
    int abandonedDone;

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.busy",   {63'd0, busy},        64'd0);
    checkOutput("reset.done",   {63'd0, done},        64'd0);
    checkOutput("reset.result", result,               64'd0);
    checkOutput("reset.dbz",    {63'd0, div_by_zero}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed corner cases; each start after the first lands in the done cycle.
    for (int i = 0; i < 9; i++) begin
      applyStimulus($sformatf("dir%0d", i), dirA[i], dirB[i], 0);
    end

    // done must be a single-cycle pulse.
    @(posedge clk);
    #1;
    checkOutput("donePulse", {63'd0, done}, 64'd0);
    checkOutput("resultHeld", result, lastExpResult);

    // Randomized operands with a bias toward small and zero divisors.
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 7);
      a = (sel == 7) ? 32'h8000_0000 : ((sel < 3) ? 32'($urandom_range(0, 1000)) : $urandom);
      if ($urandom_range(0, 1) == 1 && sel < 3) a = -a;
      sel = $urandom_range(0, 7);
      if (sel == 0)      b = 32'd0;
      else if (sel < 3)  b = 32'($urandom_range(1, 20));
      else if (sel == 3) b = 32'hFFFF_FFFF;
      else               b = $urandom;
      if ($urandom_range(0, 1) == 1 && sel < 3) b = -b;
      applyStimulus($sformatf("rnd%0d", i), a, b, 0);
    end

    // Start while busy is ignored; the follow-on start in the done cycle is taken.
    applyStimulus("busyA", 32'd1000, 32'd33, 10);
    applyStimulus("busyB", -32'sd77, 32'd4, 0);

    // Reset in the middle of a division abandons it.
    dividend = 32'd12345;
    divisor  = 32'd6;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort.busy",   {63'd0, busy},        64'd0);
    checkOutput("abort.result", result,               64'd0);
    checkOutput("abort.dbz",    {63'd0, div_by_zero}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    abandonedDone = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) abandonedDone++;
    end
    checkOutput("abort.noDone", 64'(abandonedDone), 64'd0);
    lastExpResult = '0;
    applyStimulus("afterAbort", -32'sd1000, -32'sd7, 0);

    // A start presented right after reset release is taken on the first edge.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    lastExpResult = '0;
    applyStimulus("firstEdge", 32'd99, 32'd10, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
